// File: rtl/decoder_seq_nx_pkg.sv
// rtl/decoder_seq_nx_pkg.sv - shared types and one-hot helper for decoder_seq_nx
package decoder_seq_pkg;

    typedef enum logic {IDLE, SWEEP} dec_state_t;

    // Widest one-hot vector the helper can produce; NUM_OUT must not exceed it.
    localparam int ONEHOT_MAX = 256;

    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx, input int unsigned width);
        logic [ONEHOT_MAX-1:0] r;
        r = '0;
        if (idx < width && idx < ONEHOT_MAX)
            r = ONEHOT_MAX'(1) << idx;
        return r;
    endfunction

endpackage

// File: rtl/decoder_seq_nx_dec_onehot.sv
// rtl/decoder_seq_nx_dec_onehot.sv - combinational index to one-hot decoder with in-range flag
module dec_onehot
    import decoder_seq_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int NUM_OUT = 16
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_OUT-1:0] y,
    output logic               in_range
);

    assign y        = NUM_OUT'(onehot(32'(idx), 32'(NUM_OUT)));
    assign in_range = (32'(idx) < 32'(NUM_OUT));

endmodule

// File: rtl/decoder_seq_nx.sv
// rtl/decoder_seq_nx.sv - registered one-hot decoder with sweep mode; DECODER_SEQ_HOLD_EN holds y when idle
module decoder_seq_nx
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int NUM_OUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sweep_start,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic               sel_err,
    output logic               sweep_busy,
    output logic               sweep_done
);

    localparam logic [NUM_OUT-1:0] FIRST_Y = NUM_OUT'(1);
    localparam logic               SINGLE  = (NUM_OUT == 1);

    dec_state_t         state;
    logic [SEL_W:0]     cnt;
    logic [NUM_OUT-1:0] sel_y;
    logic [NUM_OUT-1:0] cnt_y;
    logic               sel_ok;
    logic               cnt_ok;
    logic               last_step;

    dec_onehot #(.IDX_W(SEL_W), .NUM_OUT(NUM_OUT)) u_sel_dec (
        .idx      (sel),
        .y        (sel_y),
        .in_range (sel_ok)
    );

    dec_onehot #(.IDX_W(SEL_W + 1), .NUM_OUT(NUM_OUT)) u_cnt_dec (
        .idx      (cnt),
        .y        (cnt_y),
        .in_range (cnt_ok)
    );

    assign last_step = (32'(cnt) == 32'(NUM_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            sel_err    <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else if (state == SWEEP && cnt_ok) begin
            y          <= cnt_y;
            y_valid    <= 1'b1;
            cnt        <= cnt + 1'b1;
            sweep_done <= last_step;
        end else if (sweep_start) begin
            // Reached from IDLE or from the sweep exit edge, so back-to-back sweeps have no gap.
            state      <= SWEEP;
            cnt        <= {{SEL_W{1'b0}}, 1'b1};
            y          <= FIRST_Y;
            y_valid    <= 1'b1;
            sel_err    <= 1'b0;
            sweep_busy <= 1'b1;
            sweep_done <= SINGLE;
        end else begin
            state      <= IDLE;
            cnt        <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            if (en) begin
                if (sel_ok) begin
                    y       <= sel_y;
                    y_valid <= 1'b1;
                    sel_err <= 1'b0;
                end else begin
                    y       <= '0;
                    y_valid <= 1'b0;
                    sel_err <= 1'b1;
                end
            end else begin
                sel_err <= 1'b0;
`ifdef DECODER_SEQ_HOLD_EN
`else
                y       <= '0;
                y_valid <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_decoder_seq_nx.sv
// tb/tb_decoder_seq_nx.sv - self-checking bench for decoder_seq_nx at NUM_OUT 16, 12 and 1
module tb_decoder_seq_nx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  sel = '0;
    logic        sweep_start = 1'b0;

    logic [15:0] y16;
    logic [11:0] y12;
    logic [0:0]  y1;
    logic        v16, v12, v1, e16, e12, e1, b16, b12, b1, d16, d12, d1;

    always #5 clk = ~clk;

    decoder_seq_nx #(.SEL_W(4), .NUM_OUT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .sweep_start(sweep_start),
        .y(y16), .y_valid(v16), .sel_err(e16), .sweep_busy(b16), .sweep_done(d16));
    decoder_seq_nx #(.SEL_W(4), .NUM_OUT(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .sweep_start(sweep_start),
        .y(y12), .y_valid(v12), .sel_err(e12), .sweep_busy(b12), .sweep_done(d12));
    decoder_seq_nx #(.SEL_W(4), .NUM_OUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .sweep_start(sweep_start),
        .y(y1), .y_valid(v1), .sel_err(e1), .sweep_busy(b1), .sweep_done(d1));

    logic [15:0] act_y [3];
    logic        act_v [3], act_e [3], act_b [3], act_d [3];

    always_comb begin
        act_y[0] = y16;          act_y[1] = {4'b0, y12};  act_y[2] = {15'b0, y1};
        act_v[0] = v16;          act_v[1] = v12;          act_v[2] = v1;
        act_e[0] = e16;          act_e[1] = e12;          act_e[2] = e1;
        act_b[0] = b16;          act_b[1] = b12;          act_b[2] = b1;
        act_d[0] = d16;          act_d[1] = d12;          act_d[2] = d1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is a run of indices nxt..n-1 still to be shown.
    int          nn [3] = '{16, 12, 1};
    logic [15:0] ey [3];
    bit          ev [3], ee [3], eb [3], ed [3], insw [3];
    int          nxt [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ey[k] = '0; ev[k] = 0; ee[k] = 0; eb[k] = 0; ed[k] = 0; insw[k] = 0; nxt[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (insw[k]) begin
                ey[k] = 16'(1) << nxt[k]; ev[k] = 1; ee[k] = 0; eb[k] = 1;
                ed[k] = (nxt[k] == nn[k] - 1);
                nxt[k]++;
                insw[k] = (nxt[k] < nn[k]);
            end else if (sweep_start) begin
                ey[k] = 16'd1; ev[k] = 1; ee[k] = 0; eb[k] = 1; ed[k] = (nn[k] == 1);
                nxt[k] = 1;
                insw[k] = (nn[k] > 1);
            end else begin
                eb[k] = 0; ed[k] = 0;
                if (en) begin
                    if (int'(sel) < nn[k]) begin ey[k] = 16'(1) << sel; ev[k] = 1; ee[k] = 0; end
                    else begin ey[k] = '0; ev[k] = 0; ee[k] = 1; end
                end else begin
                    ee[k] = 0;
`ifndef DECODER_SEQ_HOLD_EN
                    ey[k] = '0; ev[k] = 0;
`endif
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("n%0d.y", nn[k]), int'(act_y[k]), int'(ey[k]));
            check($sformatf("n%0d.y_valid", nn[k]), int'(act_v[k]), int'(ev[k]));
            check($sformatf("n%0d.sel_err", nn[k]), int'(act_e[k]), int'(ee[k]));
            check($sformatf("n%0d.sweep_busy", nn[k]), int'(act_b[k]), int'(eb[k]));
            check($sformatf("n%0d.sweep_done", nn[k]), int'(act_d[k]), int'(ed[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    typedef struct {
        bit          en;
        logic [3:0]  sel;
        logic [15:0] y16;
        bit          e16;
        logic [15:0] y12;
        bit          e12;
    } vec_t;

    vec_t tbl [$];
    int   busy_cnt, done_cnt, done_ok;

    initial begin
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1, 4'(i), 16'(1) << i, 0, (i < 12) ? 16'(1) << i : 16'h0, i >= 12});
        tbl.push_back('{1, 4'd12, 16'h1000, 0, 16'h0000, 1});
        tbl.push_back('{1, 4'd15, 16'h8000, 0, 16'h0000, 1});
        tbl.push_back('{1, 4'd11, 16'h0800, 0, 16'h0800, 0});
        tbl.push_back('{1, 4'd3,  16'h0008, 0, 16'h0008, 0});
`ifdef DECODER_SEQ_HOLD_EN
        tbl.push_back('{0, 4'd9,  16'h0008, 0, 16'h0008, 0});
        tbl.push_back('{0, 4'd0,  16'h0008, 0, 16'h0008, 0});
`else
        tbl.push_back('{0, 4'd9,  16'h0000, 0, 16'h0000, 0});
        tbl.push_back('{0, 4'd0,  16'h0000, 0, 16'h0000, 0});
`endif

        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;

        // Direct decode and out-of-range vectors
        foreach (tbl[i]) begin
            en = tbl[i].en; sel = tbl[i].sel; sweep_start = 1'b0;
            cycle();
            check($sformatf("tbl%0d.y16", i), int'(y16), int'(tbl[i].y16));
            check($sformatf("tbl%0d.v16", i), int'(v16), int'(tbl[i].y16 != 0));
            check($sformatf("tbl%0d.e16", i), int'(e16), int'(tbl[i].e16));
            check($sformatf("tbl%0d.y12", i), int'(y12), int'(tbl[i].y12));
            check($sformatf("tbl%0d.v12", i), int'(v12), int'(tbl[i].y12 != 0));
            check($sformatf("tbl%0d.e12", i), int'(e12), int'(tbl[i].e12));
        end

        // Sweep start wins over a simultaneous en
        en = 1'b1; sel = 4'd5; sweep_start = 1'b1;
        cycle();
        check("sweep_first_y", int'(y16), 1);
        check("sweep_first_err", int'(e16), 0);
        busy_cnt = int'(b16); done_cnt = int'(d16); done_ok = 1;
        en = 1'b0; sweep_start = 1'b0;
        for (int i = 1; i < 17; i++) begin
            cycle();
            busy_cnt += int'(b16);
            done_cnt += int'(d16);
            if (d16 && y16 != 16'h8000) done_ok = 0;
        end
        check("sweep_busy_cycles", busy_cnt, 16);
        check("sweep_done_count", done_cnt, 1);
        check("sweep_done_with_last", done_ok, 1);

        // Asynchronous reset in the middle of a sweep
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        repeat (4) cycle();
        check("mid_sweep_y", int'(y16), 16'h0010);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        #1 rst_n = 1'b1;
        repeat (3) cycle();
        sweep_start = 1'b1;
        cycle();
        check("restart_y", int'(y16), 1);
        sweep_start = 1'b0;
        repeat (18) cycle();

        // Start during the done cycle is ignored; start on the exit edge chains a new sweep
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        repeat (14) cycle();
        sweep_start = 1'b1;
        cycle();
        check("chain_done_y", int'(y16), 16'h8000);
        check("chain_done", int'(d16), 1);
        cycle();
        check("chain_new_y", int'(y16), 1);
        check("chain_new_busy", int'(b16), 1);
        sweep_start = 1'b0;
        repeat (17) cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            en = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(0, 15));
            sweep_start = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
